// File: rtl/compare_sequencer.sv
// compare_sequencer
//
// Initiator/consumer end of the team's combinational equality comparator.
// An operand pair is accepted over a valid/ready input, driven onto the
// comparator from registers, held there for SETTLE cycles so the comparator
// output can settle, and then cmp_equal is sampled. The verdict is offered
// over a valid/ready output, and saturating match/mismatch counters keep a
// running tally of verdicts.
//
// Parameters
//   W       operand width, must match the comparator
//   SETTLE  cycles the operands are held before sampling (>= 1)
//   CNT_W   width of the verdict counters
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   in_valid/in_ready        operand pair handshake (in_ready is combinational)
//   in_a, in_b               operand pair
//   cmp_a, cmp_b             registered operands to the comparator
//   cmp_equal                comparator result
//   out_valid/out_ready      verdict handshake
//   out_equal                sampled verdict, 1 = operands equal
//   cnt_clr                  synchronous clear of both counters
//   match_count              saturating count of equal verdicts
//   mismatch_count           saturating count of unequal verdicts

module compare_sequencer #(
  parameter int W      = 16,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  output logic [W-1:0]     cmp_a,
  output logic [W-1:0]     cmp_b,
  input  logic             cmp_equal,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_equal,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] match_count,
  output logic [CNT_W-1:0] mismatch_count
);

  // A zero settle time would sample the comparator in the same cycle the
  // operands are registered, which the protocol cannot express.
  generate
    if (SETTLE < 1) begin : g_settle_check
      $error("compare_sequencer: SETTLE must be >= 1");
    end
  endgenerate

  // The settle counter only has to hold SETTLE-1; keep at least one bit so
  // SETTLE=1 still yields a legal vector.
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0]    SETTLE_LOAD = SW'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_RESULT
  } state_t;

  state_t        state;
  logic [SW-1:0] scnt;

  // Ready only while idle; masking with rst keeps upstream from believing a
  // pair was taken on an edge where reset wins.
  assign in_ready = (state == ST_IDLE) && !rst;

  // Sequencer. Capture a pair, count down the settle window, sample the
  // comparator into the verdict register and tally it, then hold the verdict
  // until downstream takes it. A clear on the sample edge is applied after
  // the tally so the counters end at zero while the verdict itself is still
  // delivered on out_equal.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      scnt           <= '0;
      cmp_a          <= '0;
      cmp_b          <= '0;
      out_valid      <= 1'b0;
      out_equal      <= 1'b0;
      match_count    <= '0;
      mismatch_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            cmp_a <= in_a;
            cmp_b <= in_b;
            scnt  <= SETTLE_LOAD;
            state <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (scnt != '0) begin
            scnt <= scnt - SW'(1);
          end else begin
            out_equal <= cmp_equal;
            out_valid <= 1'b1;
            state     <= ST_RESULT;
            if (cmp_equal) begin
              if (match_count != CNT_MAX) begin
                match_count <= match_count + CNT_W'(1);
              end
            end else begin
              if (mismatch_count != CNT_MAX) begin
                mismatch_count <= mismatch_count + CNT_W'(1);
              end
            end
          end
        end
        ST_RESULT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase

      if (cnt_clr) begin
        match_count    <= '0;
        mismatch_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_compare_sequencer.sv
// Self-checking bench for compare_sequencer. Two instances share every
// stimulus input: one with 16-bit counters and one with 2-bit counters so
// that saturation is exercised constantly. A cycle-level behavioural model
// predicts every output; directed phases also pin literal values.

module tb_compare_sequencer;

  localparam int W      = 16;
  localparam int SETTLE = 2;
  localparam int CNT_W  = 16;
  localparam int CNT_WS = 2;
  localparam longint MAX_L = (64'd1 << CNT_W) - 1;
  localparam longint MAX_S = (64'd1 << CNT_WS) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic              cnt_clr = 1'b0;
  logic [W-1:0]      in_a = '0;
  logic [W-1:0]      in_b = '0;

  logic              in_ready, in_ready_s;
  logic [W-1:0]      cmp_a, cmp_b, cmp_a_s, cmp_b_s;
  logic              cmp_equal, cmp_equal_s;
  logic              out_valid, out_valid_s, out_equal, out_equal_s;
  logic [CNT_W-1:0]  match_count, mismatch_count;
  logic [CNT_WS-1:0] match_count_s, mismatch_count_s;

  // The comparator each sequencer drives.
  assign cmp_equal   = (cmp_a == cmp_b);
  assign cmp_equal_s = (cmp_a_s == cmp_b_s);

  compare_sequencer #(.W(W), .SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .cmp_a(cmp_a), .cmp_b(cmp_b),
    .cmp_equal(cmp_equal), .out_valid(out_valid), .out_ready(out_ready),
    .out_equal(out_equal), .cnt_clr(cnt_clr), .match_count(match_count),
    .mismatch_count(mismatch_count)
  );

  compare_sequencer #(.W(W), .SETTLE(SETTLE), .CNT_W(CNT_WS)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_a(in_a), .in_b(in_b), .cmp_a(cmp_a_s), .cmp_b(cmp_b_s),
    .cmp_equal(cmp_equal_s), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_equal(out_equal_s), .cnt_clr(cnt_clr), .match_count(match_count_s),
    .mismatch_count(mismatch_count_s)
  );

  int total = 0;
  int bad   = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a pair is busy from its accept edge; its verdict
  // appears SETTLE edges later and is retired on the first edge with
  // out_ready. Counters are plain saturating integers.
  int          cyc = 0;
  bit          m_busy = 0, m_valid = 0, m_eq = 0;
  logic [W-1:0] m_a = '0, m_b = '0;
  int          m_due = 0;
  longint      m_match = 0, m_mis = 0, m_match_s = 0, m_mis_s = 0;

  function automatic longint satInc(input longint v, input longint mx);
    return (v < mx) ? v + 1 : v;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_busy = 0; m_valid = 0; m_eq = 0; m_a = '0; m_b = '0;
      m_match = 0; m_mis = 0; m_match_s = 0; m_mis_s = 0;
    end else begin
      if (!m_busy) begin
        if (in_valid) begin
          m_busy = 1; m_a = in_a; m_b = in_b; m_due = cyc + SETTLE;
        end
      end else if (!m_valid) begin
        if (cyc == m_due) begin
          m_valid = 1;
          m_eq = (m_a == m_b);
          if (m_eq) begin
            m_match = satInc(m_match, MAX_L); m_match_s = satInc(m_match_s, MAX_S);
          end else begin
            m_mis = satInc(m_mis, MAX_L); m_mis_s = satInc(m_mis_s, MAX_S);
          end
        end
      end else if (out_ready) begin
        m_valid = 0; m_busy = 0;
      end
      if (cnt_clr) begin
        m_match = 0; m_mis = 0; m_match_s = 0; m_mis_s = 0;
      end
    end
  end

  // Compare process: every falling edge once the first reset has been applied.
  bit cmp_en = 0;
  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("in_ready", {31'd0, in_ready}, {31'd0, (!m_busy && !rst)});
      checkOutput("in_ready_s", {31'd0, in_ready_s}, {31'd0, (!m_busy && !rst)});
      checkOutput("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      checkOutput("out_valid_s", {31'd0, out_valid_s}, {31'd0, m_valid});
      if (m_valid) begin
        checkOutput("out_equal", {31'd0, out_equal}, {31'd0, m_eq});
        checkOutput("out_equal_s", {31'd0, out_equal_s}, {31'd0, m_eq});
      end
      checkOutput("cmp_a", {16'd0, cmp_a}, {16'd0, m_a});
      checkOutput("cmp_b", {16'd0, cmp_b}, {16'd0, m_b});
      checkOutput("match_count", {16'd0, match_count}, 32'(m_match));
      checkOutput("mismatch_count", {16'd0, mismatch_count}, 32'(m_mis));
      checkOutput("match_count_s", {30'd0, match_count_s}, 32'(m_match_s));
      checkOutput("mismatch_count_s", {30'd0, mismatch_count_s}, 32'(m_mis_s));
    end
  end

  // Delivery log used by the back-to-back phase.
  bit     rec_en = 0;
  time    dlv_t[$];
  bit     dlv_eq[$];
  always @(negedge clk) begin
    if (rec_en && out_valid && out_ready) begin
      dlv_t.push_back($time);
      dlv_eq.push_back(out_equal);
    end
  end

  // Inputs change 2ns after a rising edge; literal checks sample on the
  // falling edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b1; in_valid = 1'b0; cnt_clr = 1'b0;
    step();
    rst = 1'b0;
  endtask

  // Offer a pair and return 2ns after the edge that accepted it.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
    bit took = 0;
    in_valid = 1'b1; in_a = a; in_b = b;
    for (int i = 0; i < 40 && !took; i++) begin
      look();
      took = in_ready;
      step();
    end
    if (!took) checkOutput("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset state.
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    cmp_en = 1;
    look();
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_match", {16'd0, match_count}, 32'd0);
    checkOutput("rst_cmp_a", {16'd0, cmp_a}, 32'd0);

    // Unequal pair: verdict two cycles after accept.
    out_ready = 1'b0;
    step();
    applyStimulus(16'h0000, 16'hAAFF);
    look();
    checkOutput("ne_valid_n0", {31'd0, out_valid}, 32'd0);
    step();
    look();
    checkOutput("ne_valid_n1", {31'd0, out_valid}, 32'd0);
    step();
    look();
    checkOutput("ne_valid_n2", {31'd0, out_valid}, 32'd1);
    checkOutput("ne_equal", {31'd0, out_equal}, 32'd0);
    checkOutput("ne_mismatch", {16'd0, mismatch_count}, 32'd1);
    checkOutput("ne_match", {16'd0, match_count}, 32'd0);
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Equal pair, then stall in RESULT with a competing offer.
    applyStimulus(16'h0022, 16'h0022);
    step();
    step();
    look();
    checkOutput("eq_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("eq_equal", {31'd0, out_equal}, 32'd1);
    checkOutput("eq_match", {16'd0, match_count}, 32'd1);
    step();
    in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h4321;
    for (int i = 0; i < 5; i++) begin
      look();
      checkOutput("stall_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("stall_equal", {31'd0, out_equal}, 32'd1);
      checkOutput("stall_in_ready", {31'd0, in_ready}, 32'd0);
      checkOutput("stall_cmp_a", {16'd0, cmp_a}, 32'h0022);
      step();
    end
    out_ready = 1'b1;
    step();
    look();
    checkOutput("release_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("release_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("hold_cmp_b", {16'd0, cmp_b}, 32'h0022);
    in_valid = 1'b0;
    out_ready = 1'b0;

    // Saturation of the 2-bit instance, clear on the fifth sample edge.
    step();
    doReset();
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(W'(k), W'(k));
      repeat (SETTLE + 1) step();
    end
    look();
    checkOutput("sat_match_s", {30'd0, match_count_s}, 32'd3);
    checkOutput("sat_match", {16'd0, match_count}, 32'd4);
    step();
    applyStimulus(16'h0055, 16'h0055);
    step();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    look();
    checkOutput("clr_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("clr_equal", {31'd0, out_equal}, 32'd1);
    checkOutput("clr_match_s", {30'd0, match_count_s}, 32'd0);
    checkOutput("clr_match", {16'd0, match_count}, 32'd0);
    step();

    // Reset in the middle of the settle window drops the pair.
    applyStimulus(16'h0005, 16'h0006);
    rst = 1'b1;
    look();
    checkOutput("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      look();
      checkOutput("drop_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("drop_in_ready", {31'd0, in_ready}, 32'd1);
      checkOutput("drop_cmp_a", {16'd0, cmp_a}, 32'd0);
      checkOutput("drop_mismatch", {16'd0, mismatch_count}, 32'd0);
      step();
    end

    // Back-to-back stream of four pairs.
    begin
      logic [W-1:0] pa [4];
      logic [W-1:0] pb [4];
      bit exp_eq [4];
      int k = 0;
      bit f;
      pa[0] = 16'h0001; pb[0] = 16'h0001; exp_eq[0] = 1;
      pa[1] = 16'h0002; pb[1] = 16'h0003; exp_eq[1] = 0;
      pa[2] = 16'h0004; pb[2] = 16'h0004; exp_eq[2] = 1;
      pa[3] = 16'h0005; pb[3] = 16'h0006; exp_eq[3] = 0;
      dlv_t.delete();
      dlv_eq.delete();
      rec_en = 1;
      out_ready = 1'b1;
      in_valid = 1'b1; in_a = pa[0]; in_b = pb[0];
      for (int i = 0; i < 60 && k < 4; i++) begin
        look();
        f = in_ready;
        step();
        if (f) begin
          k++;
          if (k < 4) begin
            in_a = pa[k]; in_b = pb[k];
          end else begin
            in_valid = 1'b0;
          end
        end
      end
      repeat (SETTLE + 3) step();
      rec_en = 0;
      checkOutput("b2b_count", 32'(dlv_t.size()), 32'd4);
      for (int i = 0; i < dlv_t.size() && i < 4; i++) begin
        checkOutput("b2b_equal", {31'd0, dlv_eq[i]}, {31'd0, exp_eq[i]});
        if (i > 0) checkOutput("b2b_spacing", 32'(dlv_t[i] - dlv_t[i-1]), 32'((SETTLE + 2) * 10));
      end
    end

    // Randomised traffic; upstream keeps its pair until it is taken.
    begin
      bit f = 0;
      in_valid = 1'b0;
      for (int i = 0; i < 600; i++) begin
        look();
        f = in_ready && in_valid;
        step();
        rst       = ($urandom_range(0, 99) == 0);
        cnt_clr   = ($urandom_range(0, 29) == 0);
        out_ready = ($urandom_range(0, 2) != 0);
        if (!in_valid || f || rst) begin
          in_valid = $urandom_range(0, 1) == 1;
          in_a = W'($urandom_range(0, 65535));
          in_b = ($urandom_range(0, 1) == 1) ? in_a : W'($urandom_range(0, 65535));
        end
      end
      rst = 1'b0;
      cnt_clr = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (SETTLE + 3) step();
    end

    cmp_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
